mem_port_arbiter: RTL and testbench

//  Shares one external memory port between the Fetch stage (instruction reads) and the Memory stage
//  (loads/stores) of the pipelined core. Serialises transactions through a small FSM, waits out

---
 rtl/mem_port_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one external memory port between instruction fetch
// (F) and load/store (M). Transactions are serialised through a three-state
// FSM. The memory-side request is held until MemReady arrives or the wait
// budget runs out. Per-stage stall requests are raised while a request is
// outstanding.
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ReqF,
    input  logic [ADDR_W-1:0]   AddrF,
    output logic [DATA_W-1:0]   InstrF,
    output logic                AckF,
    input  logic                ReqM,
    input  logic                WeM,
    input  logic [ADDR_W-1:0]   AddrM,
    input  logic [DATA_W-1:0]   WDataM,
    input  logic [DATA_W/8-1:0] ByteEnM,
    output logic [DATA_W-1:0]   RDataM,
    output logic                AckM,
    output logic                MemReq,
    output logic                MemWe,
    output logic [ADDR_W-1:0]   MemAddr,
    output logic [DATA_W-1:0]   MemWData,
    output logic [DATA_W/8-1:0] MemBe,
    input  logic [DATA_W-1:0]   MemRData,
    input  logic                MemReady,
    output logic                StallMemF,
    output logic                StallMemM,
    output logic                TimeoutErr
);

    localparam int BE_W  = DATA_W / 8;
    // The counter only has to reach MAX_WAIT-1: the abort fires on the
    // MAX_WAIT-th cycle without MemReady.
    localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((MAX_WAIT > 0) ? (MAX_WAIT - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DATA
    } state_t;

    state_t              state_q, state_d;
    logic                last_m_q, last_m_d;    // 1: most recent grant went to M
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [BE_W-1:0]     mem_be_q, mem_be_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                ack_f_q, ack_f_d;
    logic                ack_m_q, ack_m_d;
    logic                tmo_q, tmo_d;

    logic elig_f, elig_m, grant_f, grant_m, wait_expired;

    // A requester whose Ack is high this cycle is still holding Req for the
    // finished transfer, so it is not eligible again until the next cycle.
    // On a tie, the requester that did not win last time gets the port.
    assign elig_f       = ReqF && !ack_f_q;
    assign elig_m       = ReqM && !ack_m_q;
    assign grant_m      = elig_m && (!elig_f || !last_m_q);
    assign grant_f      = elig_f && (!elig_m || last_m_q);
    assign wait_expired = (MAX_WAIT > 0) && (cnt_q == WAIT_LAST);

    // Next-state and next-output logic for the arbitration FSM.
    always_comb begin
        state_d     = state_q;
        last_m_d    = last_m_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        instr_d     = instr_q;
        rdata_d     = rdata_q;
        ack_f_d     = 1'b0;
        ack_m_d     = 1'b0;
        tmo_d       = tmo_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (grant_m) begin
                    state_d     = S_DATA;
                    last_m_d    = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = WeM;
                    mem_addr_d  = AddrM;
                    mem_wdata_d = WDataM;
                    mem_be_d    = WeM ? ByteEnM : '1;
                end else if (grant_f) begin
                    state_d    = S_FETCH;
                    last_m_d   = 1'b0;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = AddrF;
                    mem_be_d   = '1;
                end
            end
            S_FETCH, S_DATA: begin
                if (MemReady) begin
                    state_d   = S_IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (state_q == S_FETCH) begin
                        instr_d = MemRData;
                        ack_f_d = 1'b1;
                    end else begin
                        if (!mem_we_q) begin
                            rdata_d = MemRData;
                        end
                        ack_m_d = 1'b1;
                    end
                end else if (wait_expired) begin
                    // Abort: the requester still gets its Ack so the pipeline
                    // never deadlocks, but with zero data and a sticky error.
                    state_d   = S_IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    tmo_d     = 1'b1;
                    if (state_q == S_FETCH) begin
                        instr_d = '0;
                        ack_f_d = 1'b1;
                    end else begin
                        rdata_d = '0;
                        ack_m_d = 1'b1;
                    end
                end else if (MAX_WAIT > 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            last_m_q    <= 1'b0;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            instr_q     <= '0;
            rdata_q     <= '0;
            ack_f_q     <= 1'b0;
            ack_m_q     <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_m_q    <= last_m_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            instr_q     <= instr_d;
            rdata_q     <= rdata_d;
            ack_f_q     <= ack_f_d;
            ack_m_q     <= ack_m_d;
            tmo_q       <= tmo_d;
        end
    end

    assign MemReq     = mem_req_q;
    assign MemWe      = mem_we_q;
    assign MemAddr    = mem_addr_q;
    assign MemWData   = mem_wdata_q;
    assign MemBe      = mem_be_q;
    assign InstrF     = instr_q;
    assign RDataM     = rdata_q;
    assign AckF       = ack_f_q;
    assign AckM       = ack_m_q;
    assign TimeoutErr = tmo_q;
    assign StallMemF  = ReqF && !ack_f_q;
    assign StallMemM  = ReqM && !ack_m_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus a randomized two-requester run
// checked against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int BE_W     = 4;
    localparam int MAX_WAIT = 15;
    localparam int NRAND    = 40;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ReqF = 1'b0, ReqM = 1'b0, WeM = 1'b0, MemReady = 1'b0;
    logic [ADDR_W-1:0] AddrF = '0, AddrM = '0;
    logic [DATA_W-1:0] WDataM = '0, MemRData = '0;
    logic [BE_W-1:0]   ByteEnM = '0;
    logic [DATA_W-1:0] InstrF, RDataM, MemWData;
    logic [ADDR_W-1:0] MemAddr;
    logic [BE_W-1:0]   MemBe;
    logic              AckF, AckM, MemReq, MemWe, StallMemF, StallMemM, TimeoutErr;

    int n_checks = 0;
    int n_pass   = 0;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .ReqF(ReqF), .AddrF(AddrF), .InstrF(InstrF), .AckF(AckF),
        .ReqM(ReqM), .WeM(WeM), .AddrM(AddrM), .WDataM(WDataM), .ByteEnM(ByteEnM),
        .RDataM(RDataM), .AckM(AckM),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemBe(MemBe), .MemRData(MemRData), .MemReady(MemReady),
        .StallMemF(StallMemF), .StallMemM(StallMemM), .TimeoutErr(TimeoutErr)
    );

    always #5 clk = ~clk;

    // Contents of the pretend memory: every address maps to a distinct word.
    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5C3_0F96;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; ReqF = 1'b0; ReqM = 1'b0; WeM = 1'b0; AddrF = '0; AddrM = '0;
        WDataM = '0; ByteEnM = '0; MemReady = 1'b0; MemRData = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ReqF = 1'b1; AddrF = 32'h400; MemReady = 1'b1; MemRData = 32'h1234;
        repeat (2) @(negedge clk);
        n_checks++; if (MemReq !== 1'b0) $display("FAIL reset_memreq: got %0b want 0", MemReq); else n_pass++;
        n_checks++; if (AckF !== 1'b0) $display("FAIL reset_ackf: got %0b want 0", AckF); else n_pass++;
        n_checks++; if (TimeoutErr !== 1'b0) $display("FAIL reset_tmo: got %0b want 0", TimeoutErr); else n_pass++;
        n_checks++; if (MemAddr !== 32'h0) $display("FAIL reset_memaddr: got %h want 0", MemAddr); else n_pass++;
        n_checks++; if (InstrF !== 32'h0) $display("FAIL reset_instr: got %h want 0", InstrF); else n_pass++;
        rst_n = 1'b1;
        #1;
        n_checks++; if (MemReq !== 1'b0) $display("FAIL reset_rel_c0: got %0b want 0", MemReq); else n_pass++;
        @(negedge clk);
        n_checks++; if (MemReq !== 1'b1) $display("FAIL reset_rel_c1: got %0b want 1", MemReq); else n_pass++;
        @(negedge clk);
        n_checks++; if (AckF !== 1'b1 || InstrF !== 32'h1234)
            $display("FAIL reset_first_fetch: ack %0b data %h want 1 00001234", AckF, InstrF); else n_pass++;
        ReqF = 1'b0; MemReady = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero_wait_fetch();
        do_reset();
        ReqF = 1'b1; AddrF = 32'h400; MemReady = 1'b1; MemRData = 32'h2008_0005;
        #1;
        n_checks++; if (StallMemF !== 1'b1) $display("FAIL zw_stall_c0: got %0b want 1", StallMemF); else n_pass++;
        n_checks++; if (MemReq !== 1'b0) $display("FAIL zw_memreq_c0: got %0b want 0", MemReq); else n_pass++;
        @(negedge clk);
        n_checks++; if (MemReq !== 1'b1) $display("FAIL zw_memreq_c1: got %0b want 1", MemReq); else n_pass++;
        n_checks++; if (MemAddr !== 32'h400) $display("FAIL zw_memaddr_c1: got %h want 400", MemAddr); else n_pass++;
        n_checks++; if (MemWe !== 1'b0 || MemBe !== 4'hF)
            $display("FAIL zw_we_be_c1: got we %0b be %b want 0 1111", MemWe, MemBe); else n_pass++;
        n_checks++; if (StallMemF !== 1'b1 || AckF !== 1'b0)
            $display("FAIL zw_c1: stall %0b ack %0b want 1 0", StallMemF, AckF); else n_pass++;
        @(negedge clk);
        n_checks++; if (AckF !== 1'b1) $display("FAIL zw_ack_c2: got %0b want 1", AckF); else n_pass++;
        n_checks++; if (InstrF !== 32'h2008_0005) $display("FAIL zw_instr_c2: got %h want 20080005", InstrF); else n_pass++;
        n_checks++; if (StallMemF !== 1'b0) $display("FAIL zw_stall_c2: got %0b want 0", StallMemF); else n_pass++;
        n_checks++; if (MemReq !== 1'b0) $display("FAIL zw_memreq_c2: got %0b want 0", MemReq); else n_pass++;
        ReqF = 1'b0;
        @(negedge clk);
        n_checks++; if (AckF !== 1'b0 || MemReq !== 1'b0)
            $display("FAIL zw_c3: ack %0b memreq %0b want 0 0", AckF, MemReq); else n_pass++;
        MemReady = 1'b0;
    endtask

    task automatic test_alternation();
        string seq;
        int    acks;
        seq = ""; acks = 0;
        do_reset();
        ReqF = 1'b1; AddrF = 32'h404; ReqM = 1'b1; WeM = 1'b0; AddrM = 32'h1000; MemReady = 1'b1;
        for (int c = 0; c < 20 && acks < 4; c++) begin
            MemRData = mdata(MemAddr);
            @(negedge clk);
            n_checks++; if (AckF && AckM) $display("FAIL alt_double_ack: both acks at cycle %0d", c); else n_pass++;
            if (AckM) begin
                seq = {seq, "M"}; acks++;
                n_checks++; if (RDataM !== mdata(32'h1000))
                    $display("FAIL alt_rdata: got %h want %h", RDataM, mdata(32'h1000)); else n_pass++;
            end
            if (AckF) begin
                seq = {seq, "F"}; acks++;
                n_checks++; if (InstrF !== mdata(32'h404))
                    $display("FAIL alt_instr: got %h want %h", InstrF, mdata(32'h404)); else n_pass++;
            end
        end
        ReqF = 1'b0; ReqM = 1'b0; MemReady = 1'b0;
        n_checks++; if (seq != "MFMF") $display("FAIL alt_order: got '%s' want 'MFMF'", seq); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_store_wait();
        do_reset();
        ReqM = 1'b1; WeM = 1'b0; AddrM = 32'h3000; MemReady = 1'b1; MemRData = mdata(32'h3000);
        repeat (2) @(negedge clk);
        n_checks++; if (AckM !== 1'b1 || RDataM !== mdata(32'h3000))
            $display("FAIL st_preload: ack %0b data %h want 1 %h", AckM, RDataM, mdata(32'h3000)); else n_pass++;
        ReqM = 1'b0; MemReady = 1'b0;
        @(negedge clk);
        ReqM = 1'b1; WeM = 1'b1; AddrM = 32'h2004; WDataM = 32'hCAFE_F00D; ByteEnM = 4'b0011;
        MemRData = 32'hDEAD_BEEF;
        #1;
        n_checks++; if (StallMemM !== 1'b1) $display("FAIL st_stall: got %0b want 1", StallMemM); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++; if (MemReq !== 1'b1 || MemWe !== 1'b1)
                $display("FAIL st_req_we[%0d]: req %0b we %0b want 1 1", k, MemReq, MemWe); else n_pass++;
            n_checks++; if (MemBe !== 4'b0011) $display("FAIL st_be[%0d]: got %b want 0011", k, MemBe); else n_pass++;
            n_checks++; if (MemAddr !== 32'h2004 || MemWData !== 32'hCAFE_F00D)
                $display("FAIL st_addr_data[%0d]: got %h %h want 2004 cafef00d", k, MemAddr, MemWData); else n_pass++;
            n_checks++; if (AckM !== 1'b0) $display("FAIL st_early_ack[%0d]: got %0b want 0", k, AckM); else n_pass++;
            if (k == 1) begin
                // requester lets go early; the transfer must still finish intact
                ReqM = 1'b0; WeM = 1'b0; WDataM = '0; ByteEnM = '0; AddrM = '0;
            end
            if (k == 3) MemReady = 1'b1;
        end
        @(negedge clk);
        n_checks++; if (AckM !== 1'b1) $display("FAIL st_ack: got %0b want 1", AckM); else n_pass++;
        n_checks++; if (RDataM !== mdata(32'h3000))
            $display("FAIL st_rdata_kept: got %h want %h", RDataM, mdata(32'h3000)); else n_pass++;
        n_checks++; if (MemReq !== 1'b0 || MemWe !== 1'b0)
            $display("FAIL st_release: req %0b we %0b want 0 0", MemReq, MemWe); else n_pass++;
        MemReady = 1'b0;
        @(negedge clk);
        n_checks++; if (AckM !== 1'b0) $display("FAIL st_ack_pulse: got %0b want 0", AckM); else n_pass++;
    endtask

    task automatic test_timeout();
        int   cnt;
        logic got, ack, good_ack;
        logic [31:0] data, good_data;
        do_reset();
        for (int w = 0; w < 2; w++) begin
            if (w == 0) begin ReqF = 1'b1; AddrF = 32'h500; MemRData = mdata(32'h500); end
            else begin ReqM = 1'b1; WeM = 1'b0; AddrM = 32'h4000; MemRData = mdata(32'h4000); end
            MemReady = 1'b1;
            repeat (2) @(negedge clk);
            good_ack  = (w == 0) ? AckF : AckM;
            good_data = (w == 0) ? InstrF : RDataM;
            n_checks++; if (good_ack !== 1'b1 || good_data !== ((w == 0) ? mdata(32'h500) : mdata(32'h4000)))
                $display("FAIL to_pre[%0d]: ack %0b data %h", w, good_ack, good_data); else n_pass++;
            n_checks++; if (TimeoutErr !== (w == 0 ? 1'b0 : 1'b1))
                $display("FAIL to_pre_err[%0d]: got %0b want %0d", w, TimeoutErr, w); else n_pass++;
            ReqF = 1'b0; ReqM = 1'b0; MemReady = 1'b0;
            @(negedge clk);
            if (w == 0) begin ReqF = 1'b1; AddrF = 32'h504; end
            else begin ReqM = 1'b1; AddrM = 32'h4004; end
            MemRData = 32'hFFFF_FFFF;
            cnt = 0; got = 1'b0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (MemReq) cnt++;
                ack = (w == 0) ? AckF : AckM;
                if (ack) begin got = 1'b1; break; end
            end
            data = (w == 0) ? InstrF : RDataM;
            n_checks++; if (got !== 1'b1) $display("FAIL to_ack[%0d]: no ack within 40 cycles", w); else n_pass++;
            n_checks++; if (cnt != MAX_WAIT) $display("FAIL to_wait_len[%0d]: got %0d want %0d", w, cnt, MAX_WAIT); else n_pass++;
            n_checks++; if (MemReq !== 1'b0) $display("FAIL to_memreq[%0d]: got %0b want 0", w, MemReq); else n_pass++;
            n_checks++; if (data !== 32'h0) $display("FAIL to_data[%0d]: got %h want 0", w, data); else n_pass++;
            n_checks++; if (TimeoutErr !== 1'b1) $display("FAIL to_err[%0d]: got %0b want 1", w, TimeoutErr); else n_pass++;
            ReqF = 1'b0; ReqM = 1'b0;
            @(negedge clk);
        end
        ReqF = 1'b1; AddrF = 32'h600; MemReady = 1'b1; MemRData = mdata(32'h600);
        repeat (2) @(negedge clk);
        n_checks++; if (AckF !== 1'b1 || InstrF !== mdata(32'h600))
            $display("FAIL to_after: ack %0b data %h want 1 %h", AckF, InstrF, mdata(32'h600)); else n_pass++;
        ReqF = 1'b0; MemReady = 1'b0;
        @(negedge clk);
        n_checks++; if (TimeoutErr !== 1'b1) $display("FAIL to_sticky: got %0b want 1", TimeoutErr); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic seen;
        do_reset();
        ReqM = 1'b1; WeM = 1'b0; AddrM = 32'h5000; MemReady = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (MemReq !== 1'b1) $display("FAIL rm_in_wait: got %0b want 1", MemReq); else n_pass++;
        rst_n = 1'b0; MemReady = 1'b1; MemRData = mdata(32'h5000);
        @(negedge clk);
        n_checks++; if (MemReq !== 1'b0 || AckM !== 1'b0)
            $display("FAIL rm_abandon: req %0b ack %0b want 0 0", MemReq, AckM); else n_pass++;
        rst_n = 1'b1; ReqM = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (AckM || MemReq) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) $display("FAIL rm_quiet: activity seen %0b want 0", seen); else n_pass++;
        ReqF = 1'b1; AddrF = 32'h700; MemRData = mdata(32'h700);
        @(negedge clk);
        n_checks++; if (MemReq !== 1'b1 || MemAddr !== 32'h700)
            $display("FAIL rm_idle_grant: req %0b addr %h want 1 700", MemReq, MemAddr); else n_pass++;
        @(negedge clk);
        n_checks++; if (AckF !== 1'b1 || InstrF !== mdata(32'h700))
            $display("FAIL rm_idle_ack: ack %0b data %h", AckF, InstrF); else n_pass++;
        ReqF = 1'b0; MemReady = 1'b0;
        @(negedge clk);
    endtask

    // Two independent random requesters and a random-latency memory. The
    // model tracks what each requester asked for, which memory word belongs
    // to each address, and the fairness rule on contended grants.
    task automatic test_random();
        int          f_issued, m_issued, f_done, m_done, last_g, wait_left;
        logic        f_act, m_act, m_we, pe_f, pe_m, busy;
        logic [31:0] f_addr, m_addr, m_wd, exp_rdm;
        logic [3:0]  m_be;
        f_issued = 0; m_issued = 0; f_done = 0; m_done = 0; last_g = 0; wait_left = 0;
        f_act = 1'b0; m_act = 1'b0; m_we = 1'b0; pe_f = 1'b0; pe_m = 1'b0; busy = 1'b0;
        f_addr = '0; m_addr = '0; m_wd = '0; exp_rdm = '0; m_be = '0;
        do_reset();
        for (int cyc = 0; cyc < 4000 && !(f_done == NRAND && m_done == NRAND); cyc++) begin
            @(negedge clk);
            if (MemReq && !busy) begin
                busy = 1'b1;
                wait_left = $urandom_range(0, 4);
                if (MemAddr[31]) begin
                    n_checks++; if (pe_m !== 1'b1) $display("FAIL rnd_grant_m_inel: addr %h", MemAddr); else n_pass++;
                    if (pe_f) begin
                        n_checks++; if (last_g !== 0) $display("FAIL rnd_fair_m: M granted twice under contention"); else n_pass++;
                    end
                    n_checks++; if (MemAddr !== m_addr || MemWe !== m_we || MemBe !== (m_we ? m_be : 4'hF))
                        $display("FAIL rnd_mem_m: addr %h we %0b be %b want %h %0b %b", MemAddr, MemWe, MemBe,
                                 m_addr, m_we, m_we ? m_be : 4'hF); else n_pass++;
                    if (m_we) begin
                        n_checks++; if (MemWData !== m_wd) $display("FAIL rnd_wdata: got %h want %h", MemWData, m_wd); else n_pass++;
                    end
                    last_g = 1;
                end else begin
                    n_checks++; if (pe_f !== 1'b1) $display("FAIL rnd_grant_f_inel: addr %h", MemAddr); else n_pass++;
                    if (pe_m) begin
                        n_checks++; if (last_g !== 1) $display("FAIL rnd_fair_f: F granted twice under contention"); else n_pass++;
                    end
                    n_checks++; if (MemAddr !== f_addr || MemWe !== 1'b0 || MemBe !== 4'hF)
                        $display("FAIL rnd_mem_f: addr %h we %0b be %b want %h 0 1111", MemAddr, MemWe, MemBe, f_addr); else n_pass++;
                    last_g = 0;
                end
            end else if (!MemReq) begin
                busy = 1'b0;
            end
            if (AckF) begin
                n_checks++; if (f_act !== 1'b1) $display("FAIL rnd_spurious_ackf"); else n_pass++;
                n_checks++; if (InstrF !== mdata(f_addr))
                    $display("FAIL rnd_instr: got %h want %h", InstrF, mdata(f_addr)); else n_pass++;
                f_act = 1'b0; f_done++;
            end
            if (AckM) begin
                n_checks++; if (m_act !== 1'b1) $display("FAIL rnd_spurious_ackm"); else n_pass++;
                if (!m_we) exp_rdm = mdata(m_addr);
                n_checks++; if (RDataM !== exp_rdm)
                    $display("FAIL rnd_rdata: got %h want %h (we=%0b)", RDataM, exp_rdm, m_we); else n_pass++;
                m_act = 1'b0; m_done++;
            end
            if (!f_act && f_issued < NRAND && $urandom_range(0, 3) != 0) begin
                f_act = 1'b1; f_issued++;
                f_addr = {1'b0, 29'($urandom()), 2'b00};
            end
            if (!m_act && m_issued < NRAND && $urandom_range(0, 3) != 0) begin
                m_act = 1'b1; m_issued++;
                m_we   = 1'($urandom_range(0, 1));
                m_addr = {1'b1, 29'($urandom()), 2'b00};
                m_wd   = $urandom();
                m_be   = 4'($urandom_range(1, 15));
            end
            ReqF = f_act; AddrF = f_addr;
            ReqM = m_act; WeM = m_we; AddrM = m_addr; WDataM = m_wd; ByteEnM = m_be;
            pe_f = f_act && !AckF;
            pe_m = m_act && !AckM;
            if (MemReq && busy) begin
                MemReady = (wait_left == 0);
                MemRData = (wait_left == 0) ? mdata(MemAddr) : $urandom();
                if (wait_left > 0) wait_left--;
            end else begin
                MemReady = 1'($urandom_range(0, 1));
                MemRData = $urandom();
            end
            #1;
            n_checks++; if (StallMemF !== pe_f || StallMemM !== pe_m)
                $display("FAIL rnd_stall: got %0b%0b want %0b%0b", StallMemF, StallMemM, pe_f, pe_m); else n_pass++;
        end
        n_checks++; if (f_done != NRAND || m_done != NRAND)
            $display("FAIL rnd_complete: f %0d m %0d want %0d each", f_done, m_done, NRAND); else n_pass++;
        n_checks++; if (TimeoutErr !== 1'b0) $display("FAIL rnd_no_timeout: got %0b want 0", TimeoutErr); else n_pass++;
        ReqF = 1'b0; ReqM = 1'b0; MemReady = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_zero_wait_fetch();
        test_alternation();
        test_store_wait();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
